// File: rtl/quad_input_conditioner.sv
// -----------------------------------------------------------------------------
// quad_input_conditioner
//
// Front-end for the quadrature encoder counter. Raw encoder pins are
// synchronised (2-FF per channel), de-glitched by a per-channel stability
// filter, then decoded into step/direction. Transitions where both channels
// change together are flagged as illegal.
//
// Optional feature macro: QIC_STALL_DETECT_EN
//   defined   -> 32-bit stall counter drives 'stalled'
//   undefined -> no counter, 'stalled' tied low, STALL_CYCLES ignored
//
// Parameters:
//   FILTER_LEN    clocks a synchronised input must disagree with the filtered
//                 value before the filtered value follows (1..255)
//   STALL_CYCLES  clocks without a step before 'stalled' asserts
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   chA_raw     raw encoder channel A (asynchronous)
//   chB_raw     raw encoder channel B (asynchronous)
//   invert_dir  1 = swap sense of dir
//   err_clr     one-cycle pulse, clears err and err_count
//   chA_out     filtered channel A
//   chB_out     filtered channel B
//   dir         1 = A leads B (forward), XORed with invert_dir
//   step        one-cycle pulse per valid quadrature edge
//   err         sticky illegal-transition flag
//   err_count   saturating count of illegal transitions
//   stalled     no valid step for STALL_CYCLES clocks
// -----------------------------------------------------------------------------
module quad_input_conditioner #(
    parameter int unsigned FILTER_LEN   = 4,
    parameter logic [31:0] STALL_CYCLES = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        chA_raw,
    input  logic        chB_raw,
    input  logic        invert_dir,
    input  logic        err_clr,
    output logic        chA_out,
    output logic        chB_out,
    output logic        dir,
    output logic        step,
    output logic        err,
    output logic [15:0] err_count,
    output logic        stalled
);

    localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    // Channel vectors are ordered {A, B} throughout.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       filt_q,    filt_d;
    logic [CNT_W-1:0] flt_cnt_q [2];
    logic [CNT_W-1:0] flt_cnt_d [2];

    logic [1:0]       prev_q,    prev_d;
    logic             step_q,    step_d;
    logic             dir_raw_q, dir_raw_d;
    logic             err_q,     err_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    // Position of an AB state along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   quad_pos = 2'd0;
            2'b10:   quad_pos = 2'd1;
            2'b11:   quad_pos = 2'd2;
            default: quad_pos = 2'd3;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Synchroniser stage
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {chA_raw, chB_raw};
            sync2_q <= sync1_q;
        end
    end

    // Filter stage: the filtered value follows only after FILTER_LEN
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        for (int ch = 0; ch < 2; ch++) begin
            flt_cnt_d[ch] = '0;
            if (sync2_q[ch] != filt_q[ch]) begin
                if (flt_cnt_q[ch] == CNT_LAST) begin
                    filt_d[ch] = ~filt_q[ch];
                end else begin
                    flt_cnt_d[ch] = flt_cnt_q[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q       <= 2'b00;
            flt_cnt_q[0] <= '0;
            flt_cnt_q[1] <= '0;
        end else begin
            filt_q       <= filt_d;
            flt_cnt_q[0] <= flt_cnt_d[0];
            flt_cnt_q[1] <= flt_cnt_d[1];
        end
    end

    // Decode stage: compare filtered AB against the previous sample.
    always_comb begin
        logic [1:0] delta;
        delta     = filt_q ^ prev_q;
        prev_d    = filt_q;
        step_d    = 1'b0;
        dir_raw_d = dir_raw_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (delta == 2'b11) begin
            // Illegal edge takes priority over a coincident clear.
            err_d     = 1'b1;
            err_cnt_d = err_clr ? 16'd1 : sat_inc16(err_cnt_q);
        end else begin
            if (err_clr) begin
                err_d     = 1'b0;
                err_cnt_d = 16'd0;
            end
            if (delta != 2'b00) begin
                step_d    = 1'b1;
                dir_raw_d = (quad_pos(filt_q) == quad_pos(prev_q) + 2'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 2'b00;
            step_q    <= 1'b0;
            dir_raw_q <= 1'b1;
            err_q     <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            prev_q    <= prev_d;
            step_q    <= step_d;
            dir_raw_q <= dir_raw_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef QIC_STALL_DETECT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Cleared on the same edge that raises step, so stalled drops with it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (step_d) begin
            stall_cnt_d = 32'd0;
        end else if (stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stalled = (stall_cnt_q >= STALL_CYCLES - 32'd1);
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = ^STALL_CYCLES;
    assign stalled          = 1'b0;
`endif

    assign chA_out   = filt_q[1];
    assign chB_out   = filt_q[0];
    assign step      = step_q;
    assign dir       = dir_raw_q ^ invert_dir;
    assign err       = err_q;
    assign err_count = err_cnt_q;

endmodule
